// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer producing the datapath control word
// for fetch (F0-F3) and per-opcode execute steps (E0-E5).
module control_unit (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        con_ff,
   input  logic        stop,
   output logic        run,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        HIout,
   output logic        LOout,
   output logic        ZHighOut,
   output logic        ZLowOut,
   output logic        PCout,
   output logic        MDRout,
   output logic        InPortOut,
   output logic        Cout,
   output logic        MARin,
   output logic        MDRin,
   output logic        HIin,
   output logic        LOin,
   output logic        Yin,
   output logic        Zin,
   output logic        PCin,
   output logic        IRin,
   output logic        InPortIn,
   output logic        OutPortIn,
   output logic        CONN_in,
   output logic        incPC,
   output logic        read,
   output logic        write,
   output logic [4:0]  opcode
);
   typedef enum logic [2:0] {RESET, F0, F1, F2, F3, EX, HALT} state_t;
   state_t state_q, state_d;
   logic [2:0] step_q, step_d, last_e;
   logic [4:0] op;
   logic alu, imm, ldi, ld, st, md, nn, br, jr, inp, outp, mfhi, mflo, hlt, noex;
   logic f0, f1, f2, f3, e0, e1, e2, e3, e4, e5, done, ir_unused;
   assign op = ir[31:27];
   assign ir_unused = ^ir[26:0];
   assign ld   = op == 5'd0;
   assign ldi  = op == 5'd1;
   assign st   = op == 5'd2;
   assign alu  = op >= 5'd3 && op <= 5'd11;
   assign imm  = op >= 5'd12 && op <= 5'd14;
   assign md   = op == 5'd15 || op == 5'd16;
   assign nn   = op == 5'd17 || op == 5'd18;
   assign br   = op == 5'd19;
   assign jr   = op == 5'd20;
   assign inp  = op == 5'd22;
   assign outp = op == 5'd23;
   assign mfhi = op == 5'd24;
   assign mflo = op == 5'd25;
   assign hlt  = op == 5'd27;
   assign noex = !(alu | imm | ldi | ld | st | md | nn | br | jr | inp | outp | mfhi | mflo);
   assign last_e = ld ? 3'd5 : st ? 3'd4 : (md | br) ? 3'd3 : (alu | imm | ldi) ? 3'd2 : nn ? 3'd1 : 3'd0;
   assign f0 = state_q == F0;
   assign f1 = state_q == F1;
   assign f2 = state_q == F2;
   assign f3 = state_q == F3;
   assign e0 = state_q == EX && step_q == 3'd0;
   assign e1 = state_q == EX && step_q == 3'd1;
   assign e2 = state_q == EX && step_q == 3'd2;
   assign e3 = state_q == EX && step_q == 3'd3;
   assign e4 = state_q == EX && step_q == 3'd4;
   assign e5 = state_q == EX && step_q == 3'd5;
   // an instruction ends at its last E-step, or at F3 when it has no execute phase
   assign done = (state_q == EX && step_q == last_e) || (f3 && noex);
   always_comb begin
      state_d = (state_q == HALT || (f3 && hlt)) ? HALT :
                done ? (stop ? HALT : F0) :
                state_q == RESET ? F0 : f0 ? F1 : f1 ? F2 : f2 ? F3 : EX;
      step_d  = (state_q == EX && !done) ? step_q + 3'd1 : 3'd0;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= RESET;
         step_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end
   assign run       = !(state_q == RESET || state_q == HALT);
   assign Gra       = ((alu | imm | ldi) && e2) || (ld && e5) || (st && e3) || (md && e0) || (nn && e1) ||
                      ((br | jr | inp | outp | mfhi | mflo) && e0);
   assign Grb       = ((alu | imm | ldi | ld | st) && e0) || (md && e1) || (nn && e0);
   assign Grc       = alu && e1;
   assign Rin       = ((alu | imm | ldi) && e2) || (ld && e5) || (nn && e1) || ((inp | mfhi | mflo) && e0);
   assign Rout      = ((alu | imm) && e0) || (alu && e1) || (st && e3) || (md && (e0 || e1)) ||
                      ((nn | br | jr | outp) && e0);
   assign BAout     = (ldi | ld | st) && e0;
   assign HIout     = mfhi && e0;
   assign LOout     = mflo && e0;
   assign ZHighOut  = md && e3;
   assign ZLowOut   = ((alu | imm | ldi | ld | st | md) && e2) || (nn && e1) || (br && e3 && con_ff);
   assign PCout     = f0 || (br && e1);
   assign MDRout    = f3 || (ld && e5);
   assign InPortOut = inp && e0;
   assign Cout      = ((imm | ldi | ld | st) && e1) || (br && e2);
   assign MARin     = f0 || ((ld | st) && e2);
   assign MDRin     = f2 || (ld && e4) || (st && e3);
   assign HIin      = md && e3;
   assign LOin      = md && e2;
   assign Yin       = ((alu | imm | ldi | ld | st | md) && e0) || (br && e1);
   assign Zin       = ((alu | imm | ldi | ld | st | md) && e1) || (nn && e0) || (br && e2);
   assign PCin      = (br && e3 && con_ff) || (jr && e0);
   assign IRin      = f3;
   assign InPortIn  = 1'b0;
   assign OutPortIn = outp && e0;
   assign CONN_in   = br && e0;
   assign incPC     = f0;
   assign read      = f1 || f2 || (ld && (e3 || e4));
   assign write     = st && e4;
   // immediate forms map onto add/and/or; address and branch-target sums use add
   assign opcode    = (((alu | md) && e1) || (nn && e0)) ? op :
                      (imm && e1) ? (op == 5'd12 ? 5'd3 : op == 5'd13 ? 5'd5 : 5'd6) :
                      (((ldi | ld | st) && e1) || (br && e2)) ? 5'd3 : 5'd0;
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle Moore sequencer that drives every control input of the CPU datapath: register-file select strobes, bus-source enables, register load enables, memory read/write, ALU opcode and PC increment. It sits directly upstream of the datapath. It consumes the instruction-register contents and the branch-condition flag, and produces the per-cycle control word for fetch and execute. One instruction completes before the next fetch begins. There is no pipelining.

## Interface
Parameters:
- none (opcode map below is fixed).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset; one clock, synchronous, active-high
- ir  in  32  instruction register contents; opcode = ir[31:27]
- con_ff  in  1  branch condition flag from the datapath CONN flip-flop
- stop  in  1  request halt at next instruction boundary
- run  out  1  high while sequencing; low in RESET and HALT
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode strobes
- HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout  out  1 each  bus source enables
- MARin, MDRin, HIin, LOin, Yin, Zin, PCin, IRin, InPortIn, OutPortIn, CONN_in  out  1 each  register load enables
- incPC  out  1  PC increment
- read, write  out  1 each  memory strobes
- opcode  out  5  ALU operation select; 00000 when no ALU op is active

## Operation
Opcode map: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011. Opcodes 10101 and 11100–11111 execute as nop.

States and transitions:
- RESET -> F0 -> F1 -> F2 -> F3 -> E0 … En.
- After the last E-state: go to HALT if stop is high, otherwise go to F0.
- F3 transitions straight to F0 (or HALT) for nop and undefined opcodes.
- halt: F3 -> HALT.
- HALT is absorbing until clr.

Fetch cycles:
- F0: PCout, MARin, incPC.
- F1: read.
- F2: read, MDRin.
- F3: MDRout, IRin.

Execute sequences (asserted signals per step):
- ALU reg-reg (add..rol): E0 Grb Rout Yin; E1 Grc Rout Zin opcode=ir op; E2 ZLowOut Gra Rin.
- addi/andi/ori: E0 Grb Rout Yin; E1 Cout Zin opcode=add/and/or (00011/00101/00110); E2 ZLowOut Gra Rin.
- ldi: E0 Grb BAout Yin; E1 Cout Zin opcode=00011; E2 ZLowOut Gra Rin.
- ld: same E0–E1 as ldi; E2 ZLowOut MARin; E3 read; E4 read MDRin; E5 MDRout Gra Rin.
- st: same E0–E2 as ld; E3 Gra Rout MDRin (read low); E4 write.
- mul/div: E0 Gra Rout Yin; E1 Grb Rout Zin opcode=ir op; E2 ZLowOut LOin; E3 ZHighOut HIin.
- neg/not: E0 Grb Rout Zin opcode=ir op; E1 ZLowOut Gra Rin.
- br: E0 Gra Rout CONN_in; E1 PCout Yin; E2 Cout Zin opcode=00011; E3 ZLowOut PCin only if con_ff=1, otherwise no signals.
- jr: E0 Gra Rout PCin.
- in: E0 InPortOut Gra Rin. out: E0 Gra Rout OutPortIn.
- mfhi: E0 HIout Gra Rin. mflo: E0 LOout Gra Rin.

Invariants:
- At most one bus-source enable is high in any cycle.
- read and write are never both high.

## Timing
- Outputs are decoded from the registered state and the current ir only. No input reaches an output combinationally, except con_ff gating in br E3.
- Every state lasts exactly one cycle. There are no wait inputs.
- Instruction latency is 4 fetch cycles plus execute cycles:
  - nop: 4
  - jr/in/out/mfhi/mflo: 5
  - neg/not: 6
  - ALU/imm/ldi: 7
  - mul/div/br: 8
  - st: 9
  - ld: 10
- clr high at an edge: state becomes RESET, and all outputs are 0 including run and opcode. This holds mid-instruction, aborting any pending write.
- First cycle with clr low (in RESET): the next edge enters F0, and run=1 from F0 onward.
- stop is sampled only at the final edge of an instruction. stop pulses that fall within an instruction are ignored. run drops in the cycle HALT is entered.
- ir must be stable from the F3 edge until the instruction ends. The block does not latch ir.

## Test plan
- Reset mid-ld:
  - Stimulus: assert clr during ld E3.
  - Required: the next cycle has all outputs 0 and run=0; F0 follows one cycle after clr falls, with PCout/MARin/incPC=1.
- add:
  - Stimulus: ir=0x18918000 (add, Ra=1, Rb=2, Rc=3).
  - Required: exactly 7 cycles; E1 shows opcode=00011 with Grc, Rout, Zin; E2 shows ZLowOut, Gra, Rin.
- ld vs st:
  - ld: read is high in F1, F2, E3 and E4 only; ld takes 10 cycles.
  - st: write is high only in E4, and read is low in E3.
- br:
  - con_ff=1: E3 asserts ZLowOut and PCin.
  - con_ff=0: E3 is all zero.
  - Both cases: 8 cycles, then F0.
- mul:
  - Required: E2 asserts ZLowOut with LOin, and E3 asserts ZHighOut with HIin.
  - Bus check: across the whole instruction, every cycle has at most one bus-source enable high.
- halt/stop:
  - halt opcode: enters HALT after F3; run=0 held for 20 cycles.
  - stop held during the final cycle of an add: HALT is entered instead of F0.
  - Undefined opcode 11111: completes in 4 cycles as a nop.
